// File: rtl/mcore_bitstream_reader.sv
// MSB-first bit reader over word memory: one-word prefetch, up to MAX_BITS per read, skip of up to 255 bits.
// Optional feature: define MCORE_BITREADER_PEEK_EN to make op 11 a non-consuming read.
module mcore_bitstream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BITS   = 32,
  parameter int BUF_WORDS  = 2
) (
  input  logic                    aclk,
  input  logic                    rsta,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_bits,
  output logic                    rd_valid,
  output logic [MAX_BITS-1:0]     rd_data,
  output logic                    busy,
  output logic                    err,
  output logic                    mem_req,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_gnt,
  input  logic                    mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_rdata,
  input  logic                    mem_rsp_error
);

  localparam int BUFW  = DATA_WIDTH * BUF_WORDS;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFB  = $clog2(BYTES);
  localparam int LW    = $clog2(BUFW + 1);
  localparam int CW    = (LW > 9) ? LW : 9;
  localparam logic [CW-1:0] DW_C   = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] MB_C   = CW'(MAX_BITS);
  localparam logic [CW-1:0] BUFW_C = CW'(BUFW);
  localparam logic [CW-1:0] PF_LIM = CW'(BUFW - DATA_WIDTH);
  localparam logic [1:0] OP_ATTACH = 2'b00;
  localparam logic [1:0] OP_SKIP   = 2'b01;
  localparam logic [1:0] OP_READ   = 2'b10;
  localparam logic [1:0] OP_PEEK   = 2'b11;
`ifdef MCORE_BITREADER_PEEK_EN
  localparam bit PEEK_EN = 1'b1;
`else
  localparam bit PEEK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, EXEC, WAIT_DATA} state_t;

  state_t                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [CW-1:0]         n_q, n_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BUFW-1:0]       buf_q, buf_d;
  logic [CW-1:0]         level_q, level_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic                  req_q, req_d;
  logic                  out_q, out_d;
  logic                  stale_q, stale_d;
  logic                  active_q, active_d;
  logic                  err_q, err_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [MAX_BITS-1:0]   rd_data_q, rd_data_d;

  logic                  flush, rsp_take, rsp_use;
  logic [CW-1:0]         cmd_n, step, cons, level_mid;
  logic [BUFW-1:0]       buf_mid;
  logic [DATA_WIDTH-1:0] word_in;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^cmd_addr[OFFB-1:0];
  assign cmd_n    = {{(CW-8){1'b0}}, cmd_bits};
  assign step     = (n_q > DW_C) ? DW_C : n_q;
  assign rsp_take = out_q && mem_rsp_valid;
  assign word_in  = mem_rsp_error ? '0 : mem_rsp_rdata;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    n_d        = n_q;
    addr_d     = addr_q;
    ptr_d      = ptr_q;
    req_d      = req_q;
    req_addr_d = req_addr_q;
    out_d      = out_q;
    stale_d    = stale_q;
    active_d   = active_q;
    err_d      = err_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    cons       = '0;
    flush      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d  = EXEC;
          op_d     = cmd_op;
          addr_d   = {cmd_addr[ADDR_WIDTH-1:OFFB], {OFFB{1'b0}}};
          active_d = 1'b1;
          n_d      = cmd_n;
          if (cmd_op[1] && cmd_n > MB_C) begin
            n_d   = MB_C;
            err_d = 1'b1;
          end
          if (cmd_op == OP_PEEK && !PEEK_EN) err_d = 1'b1;
        end
      end
      EXEC: begin
        case (op_q)
          OP_ATTACH: begin
            flush   = 1'b1;
            ptr_d   = addr_q;
            err_d   = 1'b0;
            state_d = IDLE;
          end
          OP_SKIP: begin
            if (n_q == '0) begin
              state_d = IDLE;
            end else if (level_q >= step) begin
              cons = step;
              n_d  = n_q - step;
              if (n_q == step) state_d = IDLE;
            end else if (!rsp_take) begin
              state_d = WAIT_DATA;
            end
          end
          default: begin
            if (op_q == OP_PEEK && !PEEK_EN) begin
              state_d = IDLE;
            end else if (level_q >= n_q) begin
              rd_valid_d = 1'b1;
              rd_data_d  = MAX_BITS'(buf_q >> (BUFW_C - n_q));
              if (op_q == OP_READ) cons = n_q;
              state_d = IDLE;
            end else if (!rsp_take) begin
              // a word landing this cycle is re-evaluated in EXEC, never parked in WAIT_DATA
              state_d = WAIT_DATA;
            end
          end
        endcase
      end
      WAIT_DATA: begin
        if (rsp_take) state_d = EXEC;
      end
      default: state_d = IDLE;
    endcase

    // buffer is left-justified: next bit to deliver sits at the MSB
    level_mid = level_q - cons;
    buf_mid   = buf_q << cons;
    rsp_use   = rsp_take && !stale_q && !flush;
    if (flush) begin
      buf_d   = '0;
      level_d = '0;
    end else if (rsp_use) begin
      buf_d   = buf_mid | ({word_in, {(BUFW-DATA_WIDTH){1'b0}}} >> level_mid);
      level_d = level_mid + DW_C;
      if (mem_rsp_error) err_d = 1'b1;
    end else begin
      buf_d   = buf_mid;
      level_d = level_mid;
    end

    if (rsp_take) begin
      out_d   = 1'b0;
      stale_d = 1'b0;
    end
    if (req_q && mem_gnt) begin
      req_d = 1'b0;
      out_d = 1'b1;
      if (!stale_q && !flush) ptr_d = ptr_q + ADDR_WIDTH'(BYTES);
    end
    // an in-flight fetch from the old stream completes normally but its data is dropped
    if (flush && (req_q || (out_q && !rsp_take))) stale_d = 1'b1;
    if (active_q && !req_q && !out_q && !flush && level_q <= PF_LIM) begin
      req_d      = 1'b1;
      req_addr_d = ptr_q;
    end
  end

  always_ff @(posedge aclk or posedge rsta) begin
    if (rsta) begin
      state_q    <= IDLE;
      op_q       <= OP_ATTACH;
      n_q        <= '0;
      addr_q     <= '0;
      buf_q      <= '0;
      level_q    <= '0;
      ptr_q      <= '0;
      req_addr_q <= '0;
      req_q      <= 1'b0;
      out_q      <= 1'b0;
      stale_q    <= 1'b0;
      active_q   <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      n_q        <= n_d;
      addr_q     <= addr_d;
      buf_q      <= buf_d;
      level_q    <= level_d;
      ptr_q      <= ptr_d;
      req_addr_q <= req_addr_d;
      req_q      <= req_d;
      out_q      <= out_d;
      stale_q    <= stale_d;
      active_q   <= active_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE) || req_q || out_q;
  assign err       = err_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign mem_req   = req_q;
  assign mem_addr  = req_addr_q;
  assign mem_we    = 1'b0;
  assign mem_be    = '1;
  assign mem_wdata = '0;

endmodule

// File: tb/tb_mcore_bitstream_reader.sv
// Scoreboard bench for mcore_bitstream_reader with a behavioural memory (grant stall, latency, error injection).
`timescale 1ns/1ps
module tb_mcore_bitstream_reader;
  logic        aclk = 1'b0;
  logic        rsta;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_bits;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        busy, err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rsp_rdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rsp_valid, mem_rsp_error;

  always #5 aclk = ~aclk;

  mcore_bitstream_reader dut (
    .aclk(aclk), .rsta(rsta),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_bits(cmd_bits),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .err(err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_error(mem_rsp_error)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_e;
  int          stall_n = 0;
  int          rsp_lat = 2;
  int          pend_cnt = 0;
  bit          inject_err = 0;
  bit          pend_err = 0;
  bit          holding = 0;
  logic [31:0] pend_addr = 0;
  logic [31:0] held_addr = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h000a8f78) return 32'h02409f96;
    if (a == 32'h000a8f7c) return 32'ha47aebaa;
    return a ^ 32'h5a5a5a5a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge aclk) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got rd_data 0x%08h expected no rd_valid", rd_data);
      end else begin
        exp_e = exp_q.pop_front();
        chk("rd_data", rd_data, exp_e);
      end
    end
  end

  // Memory model: optional grant stall, fixed response latency, one-shot error injection
  initial begin
    mem_gnt = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0; mem_rsp_error = 0;
    forever begin
      @(posedge aclk); #1;
      mem_gnt = 0; mem_rsp_valid = 0; mem_rsp_error = 0; mem_rsp_rdata = 0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          mem_rsp_valid = 1;
          mem_rsp_error = pend_err;
          mem_rsp_rdata = mem_word(pend_addr);
        end
      end
      if (mem_req === 1'b1) begin
        if (holding) chk("mem_addr_stable", mem_addr, held_addr);
        if (stall_n > 0) begin
          stall_n--;
          holding = 1;
          held_addr = mem_addr;
        end else begin
          holding = 0;
          mem_gnt = 1;
          pend_addr = mem_addr;
          pend_cnt = rsp_lat;
          pend_err = inject_err;
          inject_err = 0;
        end
      end
    end
  end

  task automatic do_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [7:0] bits);
    int n;
    @(posedge aclk); #1;
    cmd_op = op; cmd_addr = addr; cmd_bits = bits; cmd_valid = 1;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!cmd_ready && n < 500);
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept_timeout: got cmd_ready 0 expected 1 within 500 cycles");
    end
    @(posedge aclk); #1;
    cmd_valid = 0;
  endtask

  task automatic rd(input logic [7:0] bits, input logic [31:0] e);
    exp_q.push_back(e);
    do_cmd(2'b10, 32'h0, bits);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!cmd_ready && n < 500);
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got cmd_ready 0 expected 1 within 500 cycles");
    end
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while ((busy || exp_q.size() != 0) && n < 500);
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL quiet_timeout: got busy 1 expected 0 within 500 cycles");
    end
  endtask

  initial begin
    rsta = 1; cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_bits = 0;
    repeat (3) @(negedge aclk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rd_valid",  {31'd0, rd_valid},  32'd0);
    chk("rst_rd_data",   rd_data,            32'd0);
    chk("rst_err",       {31'd0, err},       32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_mem_req",   {31'd0, mem_req},   32'd0);
    chk("mem_be",        {28'd0, mem_be},    32'h0000000f);
    rsta = 0;

    // Unaligned attach address, mixed read widths
    do_cmd(2'b00, 32'h000a8f7b, 8'd0);
    rd(8'd8, 32'h02); rd(8'd8, 32'h40); rd(8'd6, 32'h27); rd(8'd8, 32'he5); rd(8'd6, 32'h2a);

    do_cmd(2'b00, 32'h000a8f78, 8'd0);
    do_cmd(2'b01, 32'h0, 8'd40);
    rd(8'd8, 32'h7a);

    do_cmd(2'b00, 32'h000a8f78, 8'd0);
    do_cmd(2'b01, 32'h0, 8'd4);
    rd(8'd32, 32'h2409f96a);
    rd(8'd0, 32'h0);
    rd(8'd8, 32'h47);
    wait_idle();
    chk("err_before_oversize", {31'd0, err}, 32'd0);
    rd(8'd40, 32'haebaa5a5);
    wait_idle();
    chk("err_oversize", {31'd0, err}, 32'd1);
    do_cmd(2'b00, 32'h000a8f78, 8'd0);
    wait_idle();
    chk("err_cleared_by_attach", {31'd0, err}, 32'd0);

`ifdef MCORE_BITREADER_PEEK_EN
    exp_q.push_back(32'h02); do_cmd(2'b11, 32'h0, 8'd8);
    exp_q.push_back(32'h02); do_cmd(2'b11, 32'h0, 8'd8);
    rd(8'd8, 32'h02);
`else
    do_cmd(2'b11, 32'h0, 8'd8);
    wait_idle();
    chk("peek_disabled_err", {31'd0, err}, 32'd1);
    rd(8'd8, 32'h02);
`endif

    // Fetch pointer wraps past the top of the address space
    do_cmd(2'b00, 32'hfffffffc, 8'd0);
    rd(8'd32, 32'ha5a5a5a6);
    rd(8'd32, 32'h5a5a5a5a);

    // Attach while a fetch is in flight: old data must not appear
    wait_quiet();
    rsp_lat = 6;
    do_cmd(2'b00, 32'h000a8f78, 8'd0);
    do_cmd(2'b00, 32'h00000100, 8'd0);
    rd(8'd8, 32'h5a);
    wait_quiet();
    rsp_lat = 2;

    // Grant stalled 10 cycles, then an error response
    stall_n = 10;
    inject_err = 1;
    do_cmd(2'b00, 32'h00000100, 8'd0);
    rd(8'd8, 32'h00);
    rd(8'd32, 32'h0000005a);
    wait_idle();
    chk("err_rsp_error", {31'd0, err}, 32'd1);
    chk("stall_consumed", 32'(stall_n), 32'd0);

    // Reset while waiting for data; the late response must be ignored
    wait_quiet();
    rsp_lat = 10;
    do_cmd(2'b00, 32'h00000200, 8'd0);
    do_cmd(2'b10, 32'h0, 8'd32);
    repeat (3) @(negedge aclk);
    chk("busy_wait_data", {31'd0, busy}, 32'd1);
    rsta = 1;
    @(negedge aclk);
    chk("rst2_busy_during", {31'd0, busy}, 32'd0);
    rsta = 0;
    repeat (15) @(negedge aclk);
    chk("rst2_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst2_rd_data",   rd_data,            32'd0);
    chk("rst2_err",       {31'd0, err},       32'd0);
    chk("rst2_busy",      {31'd0, busy},      32'd0);
    chk("rst2_mem_req",   {31'd0, mem_req},   32'd0);
    rsp_lat = 2;
    // No attach since reset: reading starts at address 0
    rd(8'd8, 32'h5a);

    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
        @(negedge aclk);
        n++;
      end
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mcore_bitstream_reader.md
MCORE_BITSTREAM_READER -- requirements
Module: mcore_bitstream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory word width (32 or 64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter MAX_BITS, default 32, maximum bits per read (1..DATA_WIDTH).
REQ-004 SHALL have parameter BUF_WORDS, default 2, bit-buffer depth in words (>=2).
REQ-005 aclk  in  1  sole clock, all logic on rising edge.
REQ-006 rsta  in  1  reset, asynchronous, active-high.
REQ-007 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-008 cmd_op  in  2  00 attach, 01 skip, 10 read, 11 peek.
REQ-009 cmd_addr  in  ADDR_WIDTH  attach byte address; low log2(DATA_WIDTH/8) bits ignored.
REQ-010 cmd_bits  in  8  bit count for skip/read/peek.
REQ-011 rd_valid  out  1  one-cycle pulse, rd_data valid.
REQ-012 rd_data  out  MAX_BITS  result, right-justified, zero-extended.
REQ-013 busy  out  1  command in progress or fetch outstanding.
REQ-014 err  out  1  sticky error flag; cleared by attach.
REQ-015 mem_req, mem_addr, mem_we, mem_be, mem_wdata  out  1/ADDR_WIDTH/1/DATA_WIDTH/8/DATA_WIDTH  memory request; mem_we=0, mem_be all ones, mem_wdata=0 always.
REQ-016 mem_gnt, mem_rsp_valid, mem_rsp_rdata, mem_rsp_error  in  1/1/DATA_WIDTH/1  grant and response.

Function
REQ-017 Bit order SHALL be MSB-first within each word, words consumed at ascending addresses.
REQ-018 FSM states SHALL be IDLE, EXEC, WAIT_DATA; cmd_ready=1 only in IDLE.
REQ-019 Accepted command SHALL move IDLE->EXEC; EXEC->WAIT_DATA when buffer level < required bits; WAIT_DATA->EXEC on response; EXEC->IDLE when complete.
REQ-020 Read with level >= cmd_bits SHALL pulse rd_valid exactly one cycle after acceptance; otherwise one cycle after the final needed response.
REQ-021 Read/peek SHALL return the next cmd_bits bits; read SHALL consume them.
REQ-022 Skip SHALL consume cmd_bits bits (0..255), at most DATA_WIDTH bits per cycle, with no rd_valid.
REQ-023 cmd_bits=0 on read/peek SHALL return rd_data=0 after one cycle and consume nothing.
REQ-024 cmd_bits>MAX_BITS on read/peek SHALL set err and be executed as MAX_BITS.
REQ-025 Attach SHALL flush the buffer, load the fetch pointer, clear err, and complete in one cycle with no rd_valid.
REQ-026 Prefetch SHALL issue when free space >= DATA_WIDTH bits and no request is outstanding; at most one request outstanding.
REQ-027 mem_req and mem_addr SHALL hold stable until mem_gnt; the fetch pointer SHALL advance by DATA_WIDTH/8 on grant.
REQ-028 A response to a request granted before an attach SHALL be discarded.
REQ-029 mem_rsp_error SHALL set err and insert an all-zero word.
REQ-030 Fetch pointer SHALL wrap modulo 2^ADDR_WIDTH.
REQ-031 busy SHALL be 1 outside IDLE or while a request is outstanding.

Reset
REQ-032 rsta SHALL immediately force IDLE, an empty buffer, fetch pointer 0, and mem_req, rd_valid, rd_data, err, busy all 0, with cmd_ready=1.
REQ-033 Reset mid-command or mid-fetch SHALL abandon the operation; a later response SHALL be ignored until the next attach.
REQ-034 After reset, read/skip before any attach SHALL fetch from address 0.

Configuration
REQ-035 With MCORE_BITREADER_PEEK_EN defined, op 11 SHALL behave as a read that does not consume bits.
REQ-036 Without MCORE_BITREADER_PEEK_EN, op 11 SHALL be accepted, set err, and return to IDLE without rd_valid or consumption.

Verification
REQ-037 Memory 0xa8f78=0x02409f96, 0xa8f7c=0xa47aebaa; attach 0xa8f78; reads 8,8,6,8,6 -> rd_data 0x02, 0x40, 0x27, 0xe5, 0x2a.
REQ-038 Same memory; attach, skip 40, read 8 -> 0x7a.
REQ-039 Same memory; attach, skip 4, read 32 -> 0x2409f96a.
REQ-040 PEEK_EN defined: attach, peek 8 twice, read 8 -> 0x02 three times. PEEK_EN undefined: peek -> err=1, no rd_valid.
REQ-041 mem_gnt held low 10 cycles -> mem_addr stable throughout; response with mem_rsp_error -> err=1, next read 8 -> 0x00.
REQ-042 Assert rsta during WAIT_DATA, then return the late response -> response ignored, all outputs at reset values, cmd_ready=1.
